costas_loop_ctrl: RTL and testbench

//  Costas-loop error detector and PI loop filter for the BPSK demodulator.

---
 rtl/costas_pkg.sv | 33 +++
 rtl/costas_lock_det.sv | 65 ++++++
 rtl/costas_loop_ctrl.sv | 149 ++++++++++++++
 tb/tb_costas_loop_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/costas_pkg.sv
// Shared definitions for the Costas-loop carrier-recovery controller.
//   DATA_W_DEF / FREQ_W_DEF : default sample and NCO word widths
//   F_CENTER_DEF            : nominal carrier frequency word
//   INT_SAT_DEF             : default integrator clamp magnitude
//   sat_s()                 : signed symmetric saturation to [-lim, +lim]
// No ports (package).
package costas_pkg;

  localparam int          DATA_W_DEF   = 32;
  localparam int          FREQ_W_DEF   = 32;
  localparam logic [31:0] F_CENTER_DEF = 32'h0CCC_CCCD;
  localparam logic [31:0] INT_SAT_DEF  = 32'h0100_0000;

  // Working width of sat_s(); callers sign-extend into it and truncate back.
  localparam int SAT_W = 64;

  // Clamp x to the symmetric range [-lim, +lim]; lim is taken as non-negative.
  function automatic logic signed [SAT_W-1:0] sat_s(
    input logic signed [SAT_W-1:0] x,
    input logic signed [SAT_W-1:0] lim
  );
    logic signed [SAT_W-1:0] r;
    if (x > lim) begin
      r = lim;
    end else if (x < -lim) begin
      r = -lim;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/costas_lock_det.sv
// Carrier lock detector: counts consecutive samples whose phase error is
// inside +/-LOCK_ERR and flags lock once LOCK_CNT of them are seen in a row.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   err_valid    : err carries a valid sample this cycle
//   err          : signed phase error of that sample
//   locked       : registered lock flag (counter == LOCK_CNT)
module costas_lock_det #(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] LOCK_ERR = 32'd4096,
  parameter logic [15:0] LOCK_CNT = 16'd1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              err_valid,
  input  logic [DATA_W-1:0] err,
  output logic              locked
);

  logic [DATA_W-1:0] err_abs_s;
  logic              in_thr_s;
  logic [15:0]       cnt_r;
  logic              locked_r;

  // Magnitude of the error and threshold compare. The most negative value
  // negates to itself, which is far above any sensible threshold anyway.
  always_comb begin
    err_abs_s = err;
    if (err[DATA_W-1]) begin
      err_abs_s = -err;
    end else begin
      err_abs_s = err;
    end
    in_thr_s = (err_abs_s < DATA_W'(LOCK_ERR));
  end

  // Consecutive in-threshold counter, saturating at LOCK_CNT.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 16'd0;
    end else if (err_valid) begin
      if (!in_thr_s) begin
        cnt_r <= 16'd0;
      end else if (cnt_r == LOCK_CNT) begin
        cnt_r <= cnt_r;
      end else begin
        cnt_r <= cnt_r + 16'd1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Lock flag registered one stage after the counter, in step with the NCO word.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked_r <= 1'b0;
    end else begin
      locked_r <= (cnt_r == LOCK_CNT);
    end
  end

  assign locked = locked_r;

endmodule

// File: rtl/costas_loop_ctrl.sv
// Costas-loop phase-error detector and PI loop filter for the BPSK demodulator.
// Three registered stages: error detect -> PI filter -> NCO word adder.
// Optional lock detector built when COSTAS_LOCK_DETECT_EN is defined;
// otherwise locked is tied low.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_in, q_in : signed low-pass-filtered I / Q arm samples
//   in_valid   : i_in/q_in valid this cycle (no backpressure)
//   freq_word  : NCO frequency control word
//   out_valid  : freq_word updated this cycle
//   err_out    : registered phase error (monitor)
//   locked     : carrier lock indication
module costas_loop_ctrl
  import costas_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                FREQ_W   = FREQ_W_DEF,
  parameter int                KP_SHIFT = 6,
  parameter int                KI_SHIFT = 12,
  parameter logic [31:0]       INT_SAT  = INT_SAT_DEF,
  parameter logic [FREQ_W-1:0] F_CENTER = FREQ_W'(F_CENTER_DEF),
  parameter logic [31:0]       LOCK_ERR = 32'd4096,
  parameter logic [15:0]       LOCK_CNT = 16'd1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_in,
  input  logic [DATA_W-1:0] q_in,
  input  logic              in_valid,
  output logic [FREQ_W-1:0] freq_word,
  output logic              out_valid,
  output logic [DATA_W-1:0] err_out,
  output logic              locked
);

  localparam logic [DATA_W-1:0] MIN_S = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_S = {1'b0, {(DATA_W-1){1'b1}}};

  // Stage 1
  logic signed [DATA_W-1:0] err_s;
  logic signed [DATA_W-1:0] err_r;
  logic                     v1_r;
  // Stage 2
  logic signed [DATA_W:0]   err_x_s;
  logic signed [DATA_W:0]   sum_s;
  logic signed [DATA_W:0]   integ_next_s;
  logic signed [DATA_W-1:0] prop_s;
  logic signed [DATA_W-1:0] prop_r;
  logic signed [DATA_W:0]   integ_r;
  logic                     v2_r;
  // Stage 3
  logic [FREQ_W-1:0]        freq_s;
  logic [FREQ_W-1:0]        freq_r;
  logic                     out_valid_r;

  // Error detector: sign of I selects Q or -Q; -(-2^(N-1)) saturates to max.
  always_comb begin
    err_s = q_in;
    if (!i_in[DATA_W-1]) begin
      err_s = q_in;
    end else if (q_in == MIN_S) begin
      err_s = MAX_S;
    end else begin
      err_s = -q_in;
    end
  end

  // Stage 1 register: phase error and its valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_r  <= 1'b0;
      err_r <= '0;
    end else begin
      v1_r <= in_valid;
      if (in_valid) begin
        err_r <= err_s;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // PI filter terms; the integrator runs one bit wider so the sum cannot wrap before the clamp.
  always_comb begin
    prop_s       = err_r >>> KP_SHIFT;
    err_x_s      = {err_r[DATA_W-1], err_r};
    sum_s        = integ_r + (err_x_s >>> KI_SHIFT);
    integ_next_s = (DATA_W+1)'(sat_s(SAT_W'(sum_s), $signed(SAT_W'(INT_SAT))));
  end

  // Stage 2 register: proportional term and integrator state.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2_r    <= 1'b0;
      prop_r  <= '0;
      integ_r <= '0;
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        prop_r  <= prop_s;
        integ_r <= integ_next_s;
      end else begin
        prop_r  <= prop_r;
        integ_r <= integ_r;
      end
    end
  end

  // NCO word: wraps modulo 2^FREQ_W like a phase increment.
  always_comb begin
    freq_s = F_CENTER + FREQ_W'(prop_r) + FREQ_W'(integ_r);
  end

  // Stage 3 register: NCO word holds between valid samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      freq_r      <= F_CENTER;
    end else begin
      out_valid_r <= v2_r;
      if (v2_r) begin
        freq_r <= freq_s;
      end else begin
        freq_r <= freq_r;
      end
    end
  end

  assign freq_word = freq_r;
  assign out_valid = out_valid_r;
  assign err_out   = err_r;

`ifdef COSTAS_LOCK_DETECT_EN
  costas_lock_det #(
    .DATA_W   (DATA_W),
    .LOCK_ERR (LOCK_ERR),
    .LOCK_CNT (LOCK_CNT)
  ) u_lock_det (
    .clk       (clk),
    .reset     (reset),
    .err_valid (v1_r),
    .err       (err_r),
    .locked    (locked)
  );
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_costas_loop_ctrl.sv
// Self-checking bench for costas_loop_ctrl. Two instances share the stimulus:
// dut_a uses default parameters, dut_b uses INT_SAT = 100 and LOCK_CNT = 8.
// A sample-level reference model predicts each output and queues it for the
// cycle it is due.
module tb_costas_loop_ctrl;

  localparam logic [31:0] FC = 32'h0CCC_CCCD;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] i_in, q_in;
  logic [31:0] fw_a, eo_a, fw_b, eo_b;
  logic        ov_a, lk_a, ov_b, lk_b;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int ov_seen  = 0;

  typedef struct {
    int          due;
    logic [31:0] fa;
    logic [31:0] fb;
    logic        la;
    logic        lb;
  } exp_t;
  exp_t pend[$];

  longint      ia, ib;
  int          ca, cb;
  logic [31:0] exp_fa, exp_fb, exp_err;
  logic        exp_la, exp_lb, exp_ov;

  always #5 clk = ~clk;

  costas_loop_ctrl dut_a (
    .clk(clk), .reset(reset), .i_in(i_in), .q_in(q_in), .in_valid(in_valid),
    .freq_word(fw_a), .out_valid(ov_a), .err_out(eo_a), .locked(lk_a)
  );

  costas_loop_ctrl #(.INT_SAT(32'd100), .LOCK_CNT(16'd8)) dut_b (
    .clk(clk), .reset(reset), .i_in(i_in), .q_in(q_in), .in_valid(in_valid),
    .freq_word(fw_b), .out_valid(ov_b), .err_out(eo_b), .locked(lk_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic longint clamp(input longint x, input longint lim);
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  // Phase error from the sign of I, saturated to the 32-bit signed range.
  function automatic longint det_err(input logic [31:0] i, input logic [31:0] q);
    longint iv = longint'($signed(i));
    longint qv = longint'($signed(q));
    longint e;
    e = (iv >= 0) ? qv : -qv;
    if (e > 64'sd2147483647) e = 64'sd2147483647;
    return e;
  endfunction

  task automatic model_reset();
    pend.delete();
    ia = 0; ib = 0; ca = 0; cb = 0;
    exp_fa = FC; exp_fb = FC; exp_err = 32'd0;
    exp_la = 1'b0; exp_lb = 1'b0;
  endtask

  // Process one accepted sample completely; outputs become visible 2 edges later.
  task automatic model_sample(input logic [31:0] i, input logic [31:0] q);
    longint e, prop, mag;
    exp_t   x;
    e       = det_err(i, q);
    exp_err = 32'(e);
    prop    = e >>> 6;
    ia      = clamp(ia + (e >>> 12), 64'sd16777216);
    ib      = clamp(ib + (e >>> 12), 64'sd100);
    mag     = (e < 0) ? -e : e;
    if (mag < 4096) begin
      ca = (ca + 1 > 1024) ? 1024 : ca + 1;
      cb = (cb + 1 > 8) ? 8 : cb + 1;
    end else begin
      ca = 0;
      cb = 0;
    end
    x.due = cyc + 2;
    x.fa  = 32'(longint'(FC) + prop + ia);
    x.fb  = 32'(longint'(FC) + prop + ib);
`ifdef COSTAS_LOCK_DETECT_EN
    x.la  = (ca == 1024);
    x.lb  = (cb == 8);
`else
    x.la  = 1'b0;
    x.lb  = 1'b0;
`endif
    pend.push_back(x);
  endtask

  task automatic step(input logic rst, input logic v, input logic [31:0] i, input logic [31:0] q);
    reset = rst; in_valid = v; i_in = i; q_in = q;
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else if (v) model_sample(i, q);
    exp_ov = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_ov = 1'b1;
      exp_fa = pend[0].fa; exp_fb = pend[0].fb;
      exp_la = pend[0].la; exp_lb = pend[0].lb;
      void'(pend.pop_front());
    end
    #1;
    if (ov_a === 1'b1) ov_seen++;
    chk("out_valid_a", 32'(ov_a), 32'(exp_ov));
    chk("out_valid_b", 32'(ov_b), 32'(exp_ov));
    chk("freq_word_a", fw_a, exp_fa);
    chk("freq_word_b", fw_b, exp_fb);
    chk("err_out_a", eo_a, exp_err);
    chk("err_out_b", eo_b, exp_err);
    chk("locked_a", 32'(lk_a), 32'(exp_la));
    chk("locked_b", 32'(lk_b), 32'(exp_lb));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, $urandom, $urandom);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; i_in = 32'd0; q_in = 32'd0;
    model_reset();

    // 1. Reset with arbitrary inputs.
    for (int k = 0; k < 4; k++) step(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
    chk("rst_freq", fw_a, 32'h0CCC_CCCD);
    chk("rst_ov", 32'(ov_a), 32'd0);
    chk("rst_lock", 32'(lk_a), 32'd0);

    // 2. Positive I, repeated sample grows the integrator.
    step(1'b0, 1'b1, 32'd1000, 32'd8192);
    idle(3);
    chk("t2_err", eo_a, 32'd8192);
    chk("t2_freq1", fw_a, FC + 32'd130);
    step(1'b0, 1'b1, 32'd1000, 32'd8192);
    idle(3);
    chk("t2_freq2", fw_a, FC + 32'd132);

    // 3. Negative I and the saturated negation corner.
    step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, -32'sd1000, 32'd8192);
    idle(3);
    chk("t3_err", eo_a, 32'hFFFF_E000);
    chk("t3_freq", fw_a, FC - 32'd130);
    step(1'b0, 1'b1, -32'sd5, 32'h8000_0000);
    idle(3);
    chk("t3_sat", eo_a, 32'h7FFF_FFFF);

    // 4. Integrator clamp on dut_b (INT_SAT = 100).
    step(1'b1, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 32'd1, 32'h0010_0000);
    idle(3);
    chk("t4_clamp_b", fw_b, FC + 32'd16484);
    chk("t4_noclamp_a", fw_a, FC + 32'd16384 + 32'd2560);

    // 5. Gapped valid pattern, then reset mid-stream.
    step(1'b1, 1'b0, 32'd0, 32'd0);
    ov_seen = 0;
    step(1'b0, 1'b1, 32'd7, 32'd300000);
    step(1'b0, 1'b0, 32'd7, 32'd999);
    step(1'b0, 1'b0, 32'd7, 32'd999);
    step(1'b0, 1'b1, -32'sd7, 32'd50000);
    idle(4);
    chk("t5_pulses", 32'(ov_seen), 32'd2);
    step(1'b0, 1'b1, 32'd1, 32'd123456);
    step(1'b0, 1'b1, 32'd1, 32'd654321);
    step(1'b1, 1'b0, 32'd0, 32'd0);
    ov_seen = 0;
    idle(5);
    chk("t5_stale", 32'(ov_seen), 32'd0);

    // 6. Lock detector on dut_b (LOCK_CNT = 8).
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 32'd1, 32'd100);
    idle(3);
`ifdef COSTAS_LOCK_DETECT_EN
    chk("t6_lock", 32'(lk_b), 32'd1);
`else
    chk("t6_lock", 32'(lk_b), 32'd0);
`endif
    chk("t6_lock_a", 32'(lk_a), 32'd0);
    step(1'b0, 1'b1, 32'd1, 32'd5000);
    idle(2);
    chk("t6_unlock", 32'(lk_b), 32'd0);

    // 7. Randomised traffic with occasional resets.
    step(1'b1, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 400; k++) begin
      int          sel;
      logic [31:0] qq;
      sel = $urandom_range(0, 3);
      case (sel)
        0: qq = $urandom;
        1: qq = 32'($urandom_range(0, 12000)) - 32'd6000;
        2: qq = 32'h8000_0000;
        default: qq = 32'($urandom_range(0, 2000000)) - 32'd1000000;
      endcase
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0), $urandom, qq);
    end
    idle(4);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
